// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - core-side memory port bundle between the core and mem_responder
interface mem_responder_if;
   logic [31:0] mem_addr;
   logic [31:0] mem_dout;
   logic [31:0] mem_din;
   logic        mem_read_en;
   logic        mem_write_en;
   logic [1:0]  mem_width;
   logic        bus_err;
   logic        timer_irq;

   modport master (
      output mem_addr, mem_dout, mem_read_en, mem_write_en, mem_width,
      input  mem_din, bus_err, timer_irq
   );

   modport slave (
      input  mem_addr, mem_dout, mem_read_en, mem_write_en, mem_width,
      output mem_din, bus_err, timer_irq
   );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word RAM responder with byte/half/word lanes and optional machine timer
// Optional timer window enabled by defining MEM_RESP_TIMER_EN.
module mem_responder #(
   parameter int          ADDR_WIDTH = 12,
   parameter logic [31:0] TIMER_BASE = 32'hFFFF_0000
) (
   input  logic           clk,
   input  logic           reset,
   mem_responder_if.slave bus
);

   logic [31:0] ram_q [0:(1 << ADDR_WIDTH) - 1];

   logic [31:0] mem_din_q, mem_din_d;
   logic        bus_err_q, bus_err_d;

   logic                  access;
   logic                  ram_hit;
   logic                  tmr_hit;
   logic                  misaligned;
   logic                  illegal;
   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] word_idx;
   logic [4:0]            lane_sh;
   logic [31:0]           lane_mask;
   logic [3:0]            be_base;
   logic [3:0]            byte_en;
   logic [31:0]           ram_word;
   logic [31:0]           lane_rd;
   logic [31:0]           wr_shift;
   logic [31:0]           tmr_rdata;

   assign access   = bus.mem_read_en | bus.mem_write_en;
   assign ram_hit  = (bus.mem_addr >> (ADDR_WIDTH + 2)) == 32'd0;
   assign word_idx = bus.mem_addr[ADDR_WIDTH+1:2];
   assign lane_sh  = {bus.mem_addr[1:0], 3'b000};

   always_comb begin
      misaligned = 1'b0;
      lane_mask  = 32'hFFFF_FFFF;
      be_base    = 4'b1111;
      case (bus.mem_width)
         2'd0: begin
            lane_mask = 32'h0000_00FF;
            be_base   = 4'b0001;
         end
         2'd1: begin
            misaligned = bus.mem_addr[0];
            lane_mask  = 32'h0000_FFFF;
            be_base    = 4'b0011;
         end
         2'd2: misaligned = bus.mem_addr[1:0] != 2'b00;
         default: misaligned = 1'b1;
      endcase
   end

   assign illegal  = access & (misaligned | ~(ram_hit | tmr_hit) |
                               (tmr_hit & (bus.mem_width != 2'd2)));
   assign byte_en  = be_base << bus.mem_addr[1:0];
   assign ram_word = ram_q[word_idx];
   assign lane_rd  = (ram_word >> lane_sh) & lane_mask;
   assign wr_shift = bus.mem_dout << lane_sh;
   // Writes sampled while reset is high are dropped along with everything else.
   assign ram_we   = bus.mem_write_en & ram_hit & ~illegal & ~reset;

   always_ff @(posedge clk) begin
      if (ram_we) begin
         for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
               ram_q[word_idx][8*i +: 8] <= wr_shift[8*i +: 8];
            end
         end
      end
   end

   always_comb begin
      mem_din_d = mem_din_q;
      bus_err_d = illegal;
      if (bus.mem_read_en) begin
         if (illegal) begin
            mem_din_d = 32'd0;
         end else if (ram_hit) begin
            mem_din_d = lane_rd;
         end else begin
            mem_din_d = tmr_rdata;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_din_q <= 32'd0;
         bus_err_q <= 1'b0;
      end else begin
         mem_din_q <= mem_din_d;
         bus_err_q <= bus_err_d;
      end
   end

   assign bus.mem_din = mem_din_q;
   assign bus.bus_err = bus_err_q;

`ifdef MEM_RESP_TIMER_EN
   logic [63:0] mtime_q, mtime_d;
   logic [63:0] mtimecmp_q, mtimecmp_d;
   logic        timer_irq_q, timer_irq_d;
   logic        tmr_we;

   assign tmr_hit = bus.mem_addr[31:4] == TIMER_BASE[31:4];
   assign tmr_we  = bus.mem_write_en & tmr_hit & ~illegal;

   always_comb begin
      case (bus.mem_addr[3:2])
         2'd0:    tmr_rdata = mtime_q[31:0];
         2'd1:    tmr_rdata = mtime_q[63:32];
         2'd2:    tmr_rdata = mtimecmp_q[31:0];
         default: tmr_rdata = mtimecmp_q[63:32];
      endcase
   end

   // A software write to either mtime half replaces the increment for that cycle.
   always_comb begin
      mtime_d    = mtime_q + 64'd1;
      mtimecmp_d = mtimecmp_q;
      if (tmr_we) begin
         case (bus.mem_addr[3:2])
            2'd0:    mtime_d    = {mtime_q[63:32], bus.mem_dout};
            2'd1:    mtime_d    = {bus.mem_dout, mtime_q[31:0]};
            2'd2:    mtimecmp_d = {mtimecmp_q[63:32], bus.mem_dout};
            default: mtimecmp_d = {bus.mem_dout, mtimecmp_q[31:0]};
         endcase
      end
      timer_irq_d = mtime_d >= mtimecmp_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mtime_q     <= 64'd0;
         mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
         timer_irq_q <= 1'b0;
      end else begin
         mtime_q     <= mtime_d;
         mtimecmp_q  <= mtimecmp_d;
         timer_irq_q <= timer_irq_d;
      end
   end

   assign bus.timer_irq = timer_irq_q;
`else
   logic unused_timer_base;

   assign tmr_hit           = 1'b0;
   assign tmr_rdata         = 32'd0;
   assign bus.timer_irq     = 1'b0;
   assign unused_timer_base = ^TIMER_BASE;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized bench for mem_responder against a byte-addressed reference model
module tb_mem_responder;
   localparam logic [31:0] BASE    = 32'hFFFF_0000;
   localparam logic [31:0] RAM_TOP = 32'h0000_4000;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   mem_responder_if bus_if();

   mem_responder #(.ADDR_WIDTH(12), .TIMER_BASE(BASE)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0]  mem_m [0:16383];
   logic [63:0] mtime_m;
   logic [63:0] cmp_m;
   logic [31:0] exp_din;
   logic        exp_err;
   logic        exp_irq;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   function automatic bit timer_on();
`ifdef MEM_RESP_TIMER_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_edge(input bit rd, input bit wr, input logic [1:0] w,
                             input logic [31:0] a, input logic [31:0] d);
      bit          is_ram, is_tmr, il;
      int          size;
      logic [31:0] v;
      logic [63:0] nt, nc;
      size   = 1 << w;
      is_ram = a < RAM_TOP;
      is_tmr = timer_on() && a >= BASE && (a - BASE) < 16;
      il     = (w == 2'd3) || (a % size != 0) || !(is_ram || is_tmr) || (is_tmr && w != 2'd2);
      exp_err = (rd || wr) && il;
      if (rd) begin
         v = 32'd0;
         if (!il && is_ram) begin
            for (int i = 0; i < size; i++) v[8*i +: 8] = mem_m[a + i];
         end else if (!il) begin
            case ((a - BASE) / 4)
               0: v = mtime_m[31:0];
               1: v = mtime_m[63:32];
               2: v = cmp_m[31:0];
               default: v = cmp_m[63:32];
            endcase
         end
         exp_din = v;
      end
      if (wr && !il && is_ram) begin
         for (int i = 0; i < size; i++) mem_m[a + i] = d[8*i +: 8];
      end
      nt = mtime_m + 64'd1;
      nc = cmp_m;
      if (wr && !il && is_tmr) begin
         case ((a - BASE) / 4)
            0: nt = {mtime_m[63:32], d};
            1: nt = {d, mtime_m[31:0]};
            2: nc = {cmp_m[63:32], d};
            default: nc = {d, cmp_m[31:0]};
         endcase
      end
      if (timer_on()) begin
         mtime_m = nt;
         cmp_m   = nc;
         exp_irq = nt >= nc;
      end else begin
         exp_irq = 1'b0;
      end
   endtask

   task automatic step(input bit rd, input bit wr, input logic [1:0] w,
                       input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      bus_if.mem_read_en  = rd;
      bus_if.mem_write_en = wr;
      bus_if.mem_width    = w;
      bus_if.mem_addr     = a;
      bus_if.mem_dout     = d;
      @(posedge clk);
      model_edge(rd, wr, w, a, d);
      #1;
      check($sformatf("din@%08h", a), bus_if.mem_din, exp_din);
      check($sformatf("err@%08h", a), {31'd0, bus_if.bus_err}, {31'd0, exp_err});
      check($sformatf("irq@%08h", a), {31'd0, bus_if.timer_irq}, {31'd0, exp_irq});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
   endtask

   task automatic model_reset();
      mtime_m = 64'd0;
      cmp_m   = 64'hFFFF_FFFF_FFFF_FFFF;
      exp_din = 32'd0;
      exp_err = 1'b0;
      exp_irq = 1'b0;
   endtask

   initial begin
      bit          rd, wr;
      logic [1:0]  w;
      logic [31:0] a;
      int          r;
      n_checks = 0;
      n_fail   = 0;
      reset = 1'b1;
      bus_if.mem_read_en  = 1'b0;
      bus_if.mem_write_en = 1'b0;
      bus_if.mem_width    = 2'd0;
      bus_if.mem_addr     = 32'd0;
      bus_if.mem_dout     = 32'd0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_din", bus_if.mem_din, 32'd0);
      check("rst_err", {31'd0, bus_if.bus_err}, 32'd0);
      check("rst_irq", {31'd0, bus_if.timer_irq}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 32'h300; i += 4) step(1'b0, 1'b1, 2'd2, i, $urandom);

      step(1'b0, 1'b1, 2'd2, 32'h100, 32'h1122_3344);
      step(1'b0, 1'b1, 2'd0, 32'h102, 32'h0000_00AB);
      step(1'b1, 1'b0, 2'd2, 32'h100, 32'd0);
      check("lane_word", bus_if.mem_din, 32'h11AB_3344);
      step(1'b1, 1'b0, 2'd1, 32'h102, 32'd0);
      check("lane_half", bus_if.mem_din, 32'h0000_11AB);

      step(1'b0, 1'b1, 2'd2, 32'h101, 32'hCAFE_F00D);
      check("misalign_err", {31'd0, bus_if.bus_err}, 32'd1);
      idle(1);
      check("err_one_cycle", {31'd0, bus_if.bus_err}, 32'd0);
      step(1'b1, 1'b0, 2'd2, 32'h100, 32'd0);
      step(1'b1, 1'b0, 2'd3, 32'h100, 32'd0);
      step(1'b1, 1'b0, 2'd2, RAM_TOP, 32'd0);
      step(1'b1, 1'b0, 2'd2, 32'h100, 32'd0);
      step(1'b1, 1'b0, 2'd3, 32'h100, 32'd0);
      step(1'b1, 1'b0, 2'd3, 32'h100, 32'd0);

      step(1'b0, 1'b1, 2'd2, 32'h200, 32'hDEAD_BEEF);
      step(1'b1, 1'b1, 2'd2, 32'h200, 32'h0);
      check("rbw_old", bus_if.mem_din, 32'hDEAD_BEEF);
      step(1'b1, 1'b0, 2'd2, 32'h200, 32'd0);
      check("rbw_new", bus_if.mem_din, 32'h0);

      step(1'b0, 1'b1, 2'd2, BASE + 32'h4, 32'd0);
      step(1'b0, 1'b1, 2'd2, BASE, 32'd0);
      step(1'b0, 1'b1, 2'd2, BASE + 32'hC, 32'd0);
      step(1'b0, 1'b1, 2'd2, BASE + 32'h8, 32'd50);
      idle(60);
      if (timer_on()) check("irq_high", {31'd0, bus_if.timer_irq}, 32'd1);
      step(1'b0, 1'b1, 2'd2, BASE + 32'h8, 32'd1000);
      if (timer_on()) check("irq_low", {31'd0, bus_if.timer_irq}, 32'd0);

      step(1'b0, 1'b1, 2'd2, BASE, 32'hFFFF_FFFE);
      step(1'b0, 1'b1, 2'd2, BASE + 32'h4, 32'd0);
      idle(2);
      step(1'b1, 1'b0, 2'd2, BASE + 32'h4, 32'd0);
      step(1'b1, 1'b0, 2'd2, BASE, 32'd0);
      step(1'b1, 1'b0, 2'd1, BASE, 32'd0);
      check("tmr_half_err", {31'd0, bus_if.bus_err}, 32'd1);

      step(1'b1, 1'b0, 2'd2, 32'h100, 32'd0);
      @(negedge clk);
      bus_if.mem_read_en = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      check("async_din", bus_if.mem_din, 32'd0);
      check("async_err", {31'd0, bus_if.bus_err}, 32'd0);
      check("async_irq", {31'd0, bus_if.timer_irq}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      bus_if.mem_read_en = 1'b0;
      model_reset();
      step(1'b1, 1'b0, 2'd2, BASE + 32'h8, 32'd0);
      step(1'b1, 1'b0, 2'd2, BASE + 32'hC, 32'd0);
      if (timer_on()) check("cmp_after_rst", bus_if.mem_din, 32'hFFFF_FFFF);
      step(1'b1, 1'b0, 2'd2, BASE, 32'd0);

      for (int n = 0; n < 400; n++) begin
         r  = $urandom_range(0, 9);
         if (r < 6)       a = $urandom_range(0, 32'h2FF);
         else if (r < 8)  a = BASE + $urandom_range(0, 15);
         else if (r == 8) a = RAM_TOP + $urandom_range(0, 255);
         else             a = $urandom_range(0, 32'h2FF) & ~32'd3;
         r  = $urandom_range(0, 7);
         w  = (r < 7) ? 2'(r % 3) : 2'd3;
         rd = $urandom_range(0, 1) == 1;
         wr = $urandom_range(0, 2) == 0;
         step(rd, wr, w, a, $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
